epidemic_fwd_ctrl: RTL and testbench
====================================

// Module: epidemic_fwd_ctrl
// PURPOSE
//  Forwarding controller for one mesh router in the epidemic-routing NoC. Sits between the
//  router's four link ports (l,r,t,b) and a local injection port. Each cycle it round-robin
//  arbitrates one packet, drops it if its ID is already in the seen-table, otherwise marks
//  the ID seen, delivers it locally, and floods it to every link except the arrival link.
// PARAMETERS
//  DATA_W  8  packet width in bits; ID field is data[DATA_W-1 -: ID_W]
//  ID_W    4  packet-ID width; the seen-table holds 2**ID_W bits
// PORTS
//  clk                 in   1       clock
//  rstn                in   1       async active-low reset
//  i_valid_{l,r,t,b}   in   1 each  link input valid
//  o_ready_{l,r,t,b}   out  1 each  link input ready
//  i_data_{l,r,t,b}    in   DATA_W  link input data
//  o_valid_{l,r,t,b}   out  1 each  link output valid
//  i_ready_{l,r,t,b}   in   1 each  link output ready from neighbour
//  o_data_{l,r,t,b}    out  DATA_W  link output data, all four driven from one register
//  i_valid_inj         in   1       local injection valid
//  o_ready_inj         out  1       local injection ready
//  i_data_inj          in   DATA_W  local injection data
//  i_seen_clr          in   1       one-cycle pulse: clear the whole seen-table
//  o_dlv_valid         out  1       one-cycle pulse: new (unseen) link packet delivered locally
//  o_dlv_data          out  DATA_W  delivered packet, valid with o_dlv_valid
//  o_busy              out  1       high while in SEND
// BEHAVIOUR
//  Reset: clk, rstn. rstn is asynchronous and active-low. While rstn is low: state=IDLE,
//   all o_valid_*=0, o_dlv_valid=0, o_data_* and o_dlv_data=0, seen-table all 0,
//   RR pointer=0 (l), o_busy=0.
//  Requesters and index: l=0, r=1, t=2, b=3, inj=4. The RR search starts at ptr and wraps
//   4->0. After each accept, ptr <= granted index + 1 (mod 5).
//  FSM states: IDLE and SEND.
//  IDLE:
//   - The grant is combinational from the i_valid_* inputs.
//   - o_ready_* is high only for the granted requester. All readies are low in SEND.
//   - Accept = granted valid && ready. On accept, the ID is looked up in the seen-table.
//     - Seen: consume and drop. Stay in IDLE and assert no output.
//     - Unseen, link arrival: set the seen bit. Next cycle o_dlv_valid=1 and
//       o_dlv_data=packet. Load the data register. Pending mask = all four links minus
//       the arrival link. Go to SEND.
//     - Unseen, inj arrival: set the seen bit. No local delivery. Pending mask = all four
//       links. Go to SEND.
//  SEND:
//   - o_valid_x = pending[x], registered.
//   - A pending bit clears on the cycle where o_valid_x && i_ready_x. Links complete
//     independently and in any order.
//   - When the mask becomes 0, the next state is IDLE, so o_valid drops the following cycle.
//   - o_data_* is held stable while any o_valid is high.
//  Latency: accept in cycle N gives o_valid_* high at N+1. The minimum period between
//   accepts is 2 cycles when all neighbours are ready (N accept, N+1 send, N+2 IDLE accept).
//  Seen-table clear: i_seen_clr clears every bit. If i_seen_clr and an accept fall in the
//   same cycle, the clear is applied first and then the accepted ID is set, so only that bit
//   remains 1. i_seen_clr does not disturb an in-flight SEND.
//  Backpressure: a neighbour holding i_ready low stalls the whole controller in SEND with no
//   timeout. No packet is dropped because of backpressure.
//  Mid-operation reset: async reset aborts SEND and clears o_valid_* immediately. The
//   in-flight packet is lost.
//  Widths: the ID is taken from the upper ID_W bits. The other bits are payload and are
//   forwarded unmodified.
// STRUCTURE
//  Package epidemic_pkg holds:
//   - port index constants (P_L..P_INJ, NPORT=5)
//   - the state enum (ST_IDLE, ST_SEND)
//   - the ID-extract function
//  Sub-module rr_arb5 implements the round-robin arbiter: 5-bit req, ptr in, one-hot grant
//   out, combinational. The seen-table, FSM, pending mask and data register stay in
//   epidemic_fwd_ctrl.
// TESTING
//  1. Single link packet: i_data_l=8'h3A, all i_ready=1.
//     -> o_ready_l=1, then o_valid_r/t/b=1 for one cycle with data 8'h3A, o_valid_l=0;
//        o_dlv_valid pulses with 8'h3A.
//  2. Duplicate drop: send 8'h3A on l, then 8'h35 on t (same ID 3).
//     -> the second packet is accepted and consumed, with no o_valid and no o_dlv_valid.
//  3. RR fairness: l, r, t, b and inj all valid with IDs 1..5, all neighbours ready.
//     -> accepts occur in order l,r,t,b,inj, one every 2 cycles.
//     -> The inj packet goes out on all 4 links and causes no dlv pulse.
//  4. Backpressure: hold i_ready_t=0 for 10 cycles during a broadcast from l.
//     -> r and b complete at once; o_valid_t stays high with stable data; o_busy=1 and all
//        o_ready=0 until t accepts; then IDLE.
//  5. Clear with collision: i_seen_clr pulsed in the same cycle ID 7 is accepted, then
//     ID 3 (seen before the clear) arrives.
//     -> ID 3 is forwarded as new; a second ID 7 is dropped.
//  6. Reset mid-SEND: drop rstn low while o_valid_b=1 and i_ready_b=0.
//     -> all outputs are 0 asynchronously; after release, a previously seen ID is forwarded.

Source files
------------

// File: rtl/epidemic_pkg.sv
// Shared constants, FSM state type and packet-ID helper for the epidemic forwarding controller.
package epidemic_pkg;

  localparam int unsigned NPORT      = 5;
  localparam int unsigned NLINK      = 4;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned MAX_DATA_W = 32;
  localparam int unsigned MAX_ID_W   = 16;

  localparam logic [IDX_W-1:0] P_L   = 3'd0;
  localparam logic [IDX_W-1:0] P_R   = 3'd1;
  localparam logic [IDX_W-1:0] P_T   = 3'd2;
  localparam logic [IDX_W-1:0] P_B   = 3'd3;
  localparam logic [IDX_W-1:0] P_INJ = 3'd4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // Packet ID is the top id_w bits of a data_w-bit packet (zero-extended into MAX_DATA_W).
  function automatic logic [MAX_ID_W-1:0] pkt_id(input logic [MAX_DATA_W-1:0] data,
                                                 input int unsigned data_w,
                                                 input int unsigned id_w);
    return MAX_ID_W'(data >> (data_w - id_w));
  endfunction

endpackage

// File: rtl/rr_arb5.sv
// Five-way combinational round-robin arbiter; search starts at ptr and wraps 4 -> 0.
module rr_arb5
  import epidemic_pkg::*;
(
  input  logic [NPORT-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NPORT-1:0] grant
);

  logic [3:0]       sum;
  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < NPORT; k++) begin
      sum = 4'(ptr) + 4'(k);
      idx = (sum >= 4'(NPORT)) ? 3'(sum - 4'(NPORT)) : 3'(sum);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/epidemic_fwd_ctrl.sv
// Epidemic-routing forwarding controller: arbitrate one packet, drop duplicates via the
// seen-table, deliver new link packets locally and flood them to all other links.
module epidemic_fwd_ctrl
  import epidemic_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ID_W   = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_valid_l,
  input  logic              i_valid_r,
  input  logic              i_valid_t,
  input  logic              i_valid_b,
  output logic              o_ready_l,
  output logic              o_ready_r,
  output logic              o_ready_t,
  output logic              o_ready_b,
  input  logic [DATA_W-1:0] i_data_l,
  input  logic [DATA_W-1:0] i_data_r,
  input  logic [DATA_W-1:0] i_data_t,
  input  logic [DATA_W-1:0] i_data_b,
  output logic              o_valid_l,
  output logic              o_valid_r,
  output logic              o_valid_t,
  output logic              o_valid_b,
  input  logic              i_ready_l,
  input  logic              i_ready_r,
  input  logic              i_ready_t,
  input  logic              i_ready_b,
  output logic [DATA_W-1:0] o_data_l,
  output logic [DATA_W-1:0] o_data_r,
  output logic [DATA_W-1:0] o_data_t,
  output logic [DATA_W-1:0] o_data_b,
  input  logic              i_valid_inj,
  output logic              o_ready_inj,
  input  logic [DATA_W-1:0] i_data_inj,
  input  logic              i_seen_clr,
  output logic              o_dlv_valid,
  output logic [DATA_W-1:0] o_dlv_data,
  output logic              o_busy
);

  localparam int unsigned NSEEN = 1 << ID_W;

  state_e             state;
  logic [IDX_W-1:0]   ptr;
  logic [NLINK-1:0]   pending;
  logic [DATA_W-1:0]  data_q;
  logic [NSEEN-1:0]   seen;
  logic               dlv_valid_q;
  logic [DATA_W-1:0]  dlv_data_q;

  logic [NPORT-1:0]   req;
  logic [NPORT-1:0]   grant;
  logic [IDX_W-1:0]   gidx;
  logic [IDX_W-1:0]   ptr_nxt;
  logic [DATA_W-1:0]  gdata;
  logic [ID_W-1:0]    gid;
  logic [NSEEN-1:0]   seen_base;
  logic [NSEEN-1:0]   seen_nxt;
  logic [NLINK-1:0]   flood;
  logic [NLINK-1:0]   link_rdy;
  logic [NLINK-1:0]   pending_nxt;
  logic               idle;
  logic               accept;
  logic               hit;

  assign req = {i_valid_inj, i_valid_b, i_valid_t, i_valid_r, i_valid_l};

  rr_arb5 u_arb (
    .req   (req),
    .ptr   (ptr),
    .grant (grant)
  );

  // Encode the one-hot grant and select the granted packet.
  always_comb begin
    gidx  = P_L;
    gdata = i_data_l;
    if (grant[P_R]) begin
      gidx  = P_R;
      gdata = i_data_r;
    end else if (grant[P_T]) begin
      gidx  = P_T;
      gdata = i_data_t;
    end else if (grant[P_B]) begin
      gidx  = P_B;
      gdata = i_data_b;
    end else if (grant[P_INJ]) begin
      gidx  = P_INJ;
      gdata = i_data_inj;
    end
  end

  assign idle    = (state == ST_IDLE);
  assign accept  = idle && (|grant);
  assign ptr_nxt = (gidx == P_INJ) ? P_L : gidx + 3'd1;
  assign gid     = ID_W'(pkt_id(MAX_DATA_W'(gdata), DATA_W, ID_W));

  // A same-cycle clear takes effect before the lookup and the set of the accepted ID.
  assign seen_base = i_seen_clr ? '0 : seen;
  assign hit       = seen_base[gid];

  always_comb begin
    seen_nxt = seen_base;
    if (accept && !hit) seen_nxt[gid] = 1'b1;
  end

  assign flood       = grant[P_INJ] ? '1 : ~grant[NLINK-1:0];
  assign link_rdy    = {i_ready_b, i_ready_t, i_ready_r, i_ready_l};
  assign pending_nxt = pending & ~link_rdy;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      ptr         <= P_L;
      pending     <= '0;
      data_q      <= '0;
      seen        <= '0;
      dlv_valid_q <= 1'b0;
      dlv_data_q  <= '0;
    end else begin
      dlv_valid_q <= 1'b0;
      seen        <= seen_nxt;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            ptr <= ptr_nxt;
            if (!hit) begin
              data_q  <= gdata;
              pending <= flood;
              state   <= ST_SEND;
              if (!grant[P_INJ]) begin
                dlv_valid_q <= 1'b1;
                dlv_data_q  <= gdata;
              end
            end
          end
        end
        ST_SEND: begin
          pending <= pending_nxt;
          if (pending_nxt == '0) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_ready_l   = idle && grant[P_L];
  assign o_ready_r   = idle && grant[P_R];
  assign o_ready_t   = idle && grant[P_T];
  assign o_ready_b   = idle && grant[P_B];
  assign o_ready_inj = idle && grant[P_INJ];

  assign o_valid_l   = pending[0];
  assign o_valid_r   = pending[1];
  assign o_valid_t   = pending[2];
  assign o_valid_b   = pending[3];
  assign o_data_l    = data_q;
  assign o_data_r    = data_q;
  assign o_data_t    = data_q;
  assign o_data_b    = data_q;
  assign o_dlv_valid = dlv_valid_q;
  assign o_dlv_data  = dlv_data_q;
  assign o_busy      = (state == ST_SEND);

endmodule

// File: tb/tb_epidemic_fwd_ctrl.sv
// Scoreboard bench for epidemic_fwd_ctrl: per-link and local-delivery expectation queues
// are filled by a seen-table model when packets are offered and drained by output monitors.
module tb_epidemic_fwd_ctrl;

  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [4:0]    vin;
  logic [DW-1:0] din [5];
  logic [3:0]    rin;
  logic          seen_clr;

  logic          o_ready_l, o_ready_r, o_ready_t, o_ready_b, o_ready_inj;
  logic          o_valid_l, o_valid_r, o_valid_t, o_valid_b;
  logic [DW-1:0] o_data_l, o_data_r, o_data_t, o_data_b;
  logic          o_dlv_valid, o_busy;
  logic [DW-1:0] o_dlv_data;

  wire [4:0] ordy = {o_ready_inj, o_ready_b, o_ready_t, o_ready_r, o_ready_l};
  wire [3:0] ov   = {o_valid_b, o_valid_t, o_valid_r, o_valid_l};

  always #5 clk = ~clk;

  epidemic_fwd_ctrl #(.DATA_W(DW), .ID_W(4)) dut (
    .clk(clk), .rstn(rstn),
    .i_valid_l(vin[0]), .i_valid_r(vin[1]), .i_valid_t(vin[2]), .i_valid_b(vin[3]),
    .o_ready_l(o_ready_l), .o_ready_r(o_ready_r), .o_ready_t(o_ready_t), .o_ready_b(o_ready_b),
    .i_data_l(din[0]), .i_data_r(din[1]), .i_data_t(din[2]), .i_data_b(din[3]),
    .o_valid_l(o_valid_l), .o_valid_r(o_valid_r), .o_valid_t(o_valid_t), .o_valid_b(o_valid_b),
    .i_ready_l(rin[0]), .i_ready_r(rin[1]), .i_ready_t(rin[2]), .i_ready_b(rin[3]),
    .o_data_l(o_data_l), .o_data_r(o_data_r), .o_data_t(o_data_t), .o_data_b(o_data_b),
    .i_valid_inj(vin[4]), .o_ready_inj(o_ready_inj), .i_data_inj(din[4]),
    .i_seen_clr(seen_clr), .o_dlv_valid(o_dlv_valid), .o_dlv_data(o_dlv_data),
    .o_busy(o_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  logic [7:0] q_l[$], q_r[$], q_t[$], q_b[$], q_d[$];
  bit mseen [16];
  logic [7:0] d3 [5] = '{8'h1C, 8'h2D, 8'h3E, 8'h4F, 8'h50};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Seen-table model: a new ID floods every link except the arrival one, plus local
  // delivery for link arrivals; a known ID produces nothing.
  task automatic expect_pkt(input int p, input logic [7:0] d);
    logic [3:0] id;
    id = d[7:4];
    if (mseen[id]) return;
    mseen[id] = 1'b1;
    if (p != 0) q_l.push_back(d);
    if (p != 1) q_r.push_back(d);
    if (p != 2) q_t.push_back(d);
    if (p != 3) q_b.push_back(d);
    if (p != 4) q_d.push_back(d);
  endtask

  task automatic clear_model();
    foreach (mseen[i]) mseen[i] = 1'b0;
  endtask

  // Output monitors: every completed handshake and every delivery pulse must match the head.
  always @(negedge clk) if (rstn) begin
    if (o_valid_l && rin[0]) begin
      if (q_l.size() == 0) check_eq("extra_l", 32'(o_valid_l), 32'd0);
      else check_eq("data_l", 32'(o_data_l), 32'(q_l.pop_front()));
    end
    if (o_valid_r && rin[1]) begin
      if (q_r.size() == 0) check_eq("extra_r", 32'(o_valid_r), 32'd0);
      else check_eq("data_r", 32'(o_data_r), 32'(q_r.pop_front()));
    end
    if (o_valid_t && rin[2]) begin
      if (q_t.size() == 0) check_eq("extra_t", 32'(o_valid_t), 32'd0);
      else check_eq("data_t", 32'(o_data_t), 32'(q_t.pop_front()));
    end
    if (o_valid_b && rin[3]) begin
      if (q_b.size() == 0) check_eq("extra_b", 32'(o_valid_b), 32'd0);
      else check_eq("data_b", 32'(o_data_b), 32'(q_b.pop_front()));
    end
    if (o_dlv_valid) begin
      if (q_d.size() == 0) check_eq("extra_dlv", 32'(o_dlv_valid), 32'd0);
      else check_eq("dlv_data", 32'(o_dlv_data), 32'(q_d.pop_front()));
    end
  end

  // Wait for a granted handshake, then withdraw that requester's valid.
  task automatic wait_accept(output int idx);
    idx = -1;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if ((ordy & vin) != 5'd0) begin
        for (int k = 4; k >= 0; k--) if (ordy[k] && vin[k]) idx = k;
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        vin[3'(idx)] = 1'b0;
        return;
      end
    end
    check_eq("accept_timeout", 32'(ordy & vin), 32'(vin));
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!o_busy && ov == 4'd0) return;
    end
    check_eq("idle_timeout", 32'(o_busy), 32'd0);
  endtask

  task automatic send(input int p, input logic [7:0] d);
    int idx;
    @(posedge clk);
    #1;
    expect_pkt(p, d);
    din[p] = d;
    vin[3'(p)] = 1'b1;
    wait_accept(idx);
    check_eq("grant", 32'(idx), 32'(p));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rstn = 1'b0;
    q_l.delete(); q_r.delete(); q_t.delete(); q_b.delete(); q_d.delete();
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int prev;
    vin = '0;
    rin = '1;
    seen_clr = 1'b0;
    foreach (din[i]) din[i] = '0;
    clear_model();

    // Reset state
    @(negedge clk);
    check_eq("rst_valid", 32'(ov), 32'd0);
    check_eq("rst_dlv", 32'(o_dlv_valid), 32'd0);
    check_eq("rst_busy", 32'(o_busy), 32'd0);
    check_eq("rst_data", 32'(o_data_l), 32'd0);
    check_eq("rst_dlv_data", 32'(o_dlv_data), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Single new link packet floods r/t/b and delivers locally
    send(0, 8'h3A);
    @(negedge clk);
    check_eq("t1_valid_vec", 32'(ov), 32'b1110);
    check_eq("t1_data", 32'(o_data_r), 32'h3A);
    check_eq("t1_dlv_valid", 32'(o_dlv_valid), 32'd1);
    check_eq("t1_dlv_data", 32'(o_dlv_data), 32'h3A);
    check_eq("t1_busy", 32'(o_busy), 32'd1);
    wait_idle();

    // Duplicate ID 3 on t is consumed silently
    send(2, 8'h35);
    @(negedge clk);
    check_eq("t2_valid_vec", 32'(ov), 32'd0);
    check_eq("t2_dlv", 32'(o_dlv_valid), 32'd0);
    check_eq("t2_busy", 32'(o_busy), 32'd0);

    // Round-robin order and 2-cycle accept spacing from a fresh pointer
    wait_idle();
    do_reset();
    @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      expect_pkt(k, d3[k]);
      din[k] = d3[k];
    end
    vin = 5'b11111;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_accept(idx);
      check_eq("rr_order", 32'(idx), 32'(k));
      if (k > 0) check_eq("rr_gap", 32'(acc_cyc - prev), 32'd2);
      prev = acc_cyc;
    end
    wait_idle();

    // Backpressure on t stalls the controller; r waits behind it
    rin[2] = 1'b0;
    send(0, 8'h6B);
    expect_pkt(1, 8'h81);
    din[1] = 8'h81;
    vin[1] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check_eq("bp_valid_t", 32'(o_valid_t), 32'd1);
      check_eq("bp_data_t", 32'(o_data_t), 32'h6B);
      check_eq("bp_busy", 32'(o_busy), 32'd1);
      check_eq("bp_ready", 32'(ordy), 32'd0);
      if (c > 0) check_eq("bp_valid_vec", 32'(ov), 32'b0100);
    end
    @(posedge clk);
    #1;
    rin[2] = 1'b1;
    wait_accept(idx);
    check_eq("bp_next_grant", 32'(idx), 32'd1);
    wait_idle();

    // Clear colliding with acceptance of ID 7; old ID 3 becomes new, second ID 7 dropped
    @(posedge clk);
    #1;
    clear_model();
    expect_pkt(3, 8'h7C);
    din[3] = 8'h7C;
    vin[3] = 1'b1;
    seen_clr = 1'b1;
    wait_accept(idx);
    seen_clr = 1'b0;
    check_eq("clr_grant", 32'(idx), 32'd3);
    send(0, 8'h3F);
    send(1, 8'h71);
    wait_idle();

    // Asynchronous reset while b is stalled mid-SEND
    rin[3] = 1'b0;
    send(0, 8'h9A);
    @(negedge clk);
    check_eq("t6_valid_b", 32'(o_valid_b), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    check_eq("t6_async_valid", 32'(ov), 32'd0);
    check_eq("t6_async_dlv", 32'(o_dlv_valid), 32'd0);
    check_eq("t6_async_busy", 32'(o_busy), 32'd0);
    check_eq("t6_async_data", 32'(o_data_b), 32'd0);
    q_b.delete();
    clear_model();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    rin[3] = 1'b1;
    send(1, 8'h3B);
    wait_idle();

    check_eq("left_l", 32'(q_l.size()), 32'd0);
    check_eq("left_r", 32'(q_r.size()), 32'd0);
    check_eq("left_t", 32'(q_t.size()), 32'd0);
    check_eq("left_b", 32'(q_b.size()), 32'd0);
    check_eq("left_dlv", 32'(q_d.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
